// File: rtl/mem_request_unit.sv
// mem_request_unit
// ----------------
// Shares one single-port, fixed-latency RAM between instruction fetch and
// data load/store. Data requests win arbitration, except that when both sides
// are waiting and data was served last, the fetch goes first, so neither side
// can starve the other. Each access holds the RAM strobe for RAM_LATENCY
// cycles, captures read data on the last strobe edge, and then pulses
// i_ready or d_ready for one cycle. All outputs are registered.
//
// Optional build macro: MEM_REQUEST_IBUF_EN
//   When defined, a one-entry fetch buffer is added. A fetch to the most
//   recently fetched address completes in one cycle without touching the RAM.
//   Any store to that address invalidates the buffer.
//
// Ports
//   clk, nrst                 clock, synchronous active-low reset
//   imem_req / imem_addr      fetch request (level) and address
//   imem_rdata / i_ready      fetched instruction, one-cycle completion pulse
//   dmem_read / dmem_write    data load / store requests (level)
//   dmem_addr / dmem_wdata    data address and store data
//   dmem_rdata / d_ready      load data, one-cycle completion pulse
//   ram_addr / ram_wdata      RAM address and write data
//   ram_ren / ram_wen         RAM read / write strobes
//   ram_rdata                 RAM read data
module mem_request_unit #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int RAM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              imem_req,
   input  logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_rdata,
   output logic              i_ready,
   input  logic              dmem_read,
   input  logic              dmem_write,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wdata,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              d_ready,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_ren,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int CNT_W = $clog2(RAM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, DATA, INSTR, DONE} state_t;
   typedef enum logic {GRANT_INSTR = 1'b0, GRANT_DATA = 1'b1} grant_t;

   state_t            r_state,      w_stateNext;
   logic [CNT_W-1:0]  r_count,      w_countNext;
   grant_t            r_lastGrant,  w_lastGrantNext;
   logic [ADDR_W-1:0] r_ramAddr,    w_ramAddrNext;
   logic [DATA_W-1:0] r_ramWdata,   w_ramWdataNext;
   logic              r_ramRen,     w_ramRenNext;
   logic              r_ramWen,     w_ramWenNext;
   logic [DATA_W-1:0] r_imemRdata,  w_imemRdataNext;
   logic [DATA_W-1:0] r_dmemRdata,  w_dmemRdataNext;
   logic              r_iReady,     w_iReadyNext;
   logic              r_dReady,     w_dReadyNext;

`ifdef MEM_REQUEST_IBUF_EN
   logic [ADDR_W-1:0] r_ibufAddr,   w_ibufAddrNext;
   logic [DATA_W-1:0] r_ibufData,   w_ibufDataNext;
   logic              r_ibufValid,  w_ibufValidNext;
   logic              w_ibufHit;
`endif

   logic w_dataReq;
   logic w_grantData;
   logic w_grantInstr;

   // Data has priority; the fetch only overtakes a waiting data request when
   // data was the previous grant, which alternates the two under contention.
   assign w_dataReq    = dmem_read | dmem_write;
   assign w_grantData  = w_dataReq & ~(imem_req & (r_lastGrant == GRANT_DATA));
   assign w_grantInstr = imem_req & ~w_grantData;

`ifdef MEM_REQUEST_IBUF_EN
   assign w_ibufHit = r_ibufValid & (imem_addr == r_ibufAddr);
`endif

   // State and output registers; reset drops strobes immediately so an
   // interrupted access never produces a ready pulse.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_lastGrant <= GRANT_INSTR;
         r_ramAddr   <= '0;
         r_ramWdata  <= '0;
         r_ramRen    <= 1'b0;
         r_ramWen    <= 1'b0;
         r_imemRdata <= '0;
         r_dmemRdata <= '0;
         r_iReady    <= 1'b0;
         r_dReady    <= 1'b0;
`ifdef MEM_REQUEST_IBUF_EN
         r_ibufAddr  <= '0;
         r_ibufData  <= '0;
         r_ibufValid <= 1'b0;
`endif
      end else begin
         r_state     <= w_stateNext;
         r_count     <= w_countNext;
         r_lastGrant <= w_lastGrantNext;
         r_ramAddr   <= w_ramAddrNext;
         r_ramWdata  <= w_ramWdataNext;
         r_ramRen    <= w_ramRenNext;
         r_ramWen    <= w_ramWenNext;
         r_imemRdata <= w_imemRdataNext;
         r_dmemRdata <= w_dmemRdataNext;
         r_iReady    <= w_iReadyNext;
         r_dReady    <= w_dReadyNext;
`ifdef MEM_REQUEST_IBUF_EN
         r_ibufAddr  <= w_ibufAddrNext;
         r_ibufData  <= w_ibufDataNext;
         r_ibufValid <= w_ibufValidNext;
`endif
      end
   end

   // Next-state and next-output logic. Requests are only looked at in IDLE;
   // once an access starts, its kind, address and store data are frozen in
   // the registered strobes/address so requestors may drop or change inputs.
   always_comb begin
      w_stateNext     = r_state;
      w_countNext     = r_count;
      w_lastGrantNext = r_lastGrant;
      w_ramAddrNext   = r_ramAddr;
      w_ramWdataNext  = r_ramWdata;
      w_ramRenNext    = r_ramRen;
      w_ramWenNext    = r_ramWen;
      w_imemRdataNext = r_imemRdata;
      w_dmemRdataNext = r_dmemRdata;
      w_iReadyNext    = 1'b0;
      w_dReadyNext    = 1'b0;
`ifdef MEM_REQUEST_IBUF_EN
      w_ibufAddrNext  = r_ibufAddr;
      w_ibufDataNext  = r_ibufData;
      w_ibufValidNext = r_ibufValid;
`endif
      case (r_state)
         IDLE: begin
            if (w_grantData) begin
               w_stateNext     = DATA;
               w_countNext     = CNT_W'(RAM_LATENCY);
               w_lastGrantNext = GRANT_DATA;
               w_ramAddrNext   = dmem_addr;
               w_ramWdataNext  = dmem_wdata;
               w_ramRenNext    = dmem_read & ~dmem_write;
               w_ramWenNext    = dmem_write;
`ifdef MEM_REQUEST_IBUF_EN
               if (dmem_write && (dmem_addr == r_ibufAddr)) begin
                  w_ibufValidNext = 1'b0;
               end
`endif
            end else if (w_grantInstr) begin
               w_lastGrantNext = GRANT_INSTR;
`ifdef MEM_REQUEST_IBUF_EN
               if (w_ibufHit) begin
                  w_stateNext     = DONE;
                  w_iReadyNext    = 1'b1;
                  w_imemRdataNext = r_ibufData;
               end else
`endif
               begin
                  w_stateNext   = INSTR;
                  w_countNext   = CNT_W'(RAM_LATENCY);
                  w_ramAddrNext = imem_addr;
                  w_ramRenNext  = 1'b1;
                  w_ramWenNext  = 1'b0;
               end
            end
         end
         DATA, INSTR: begin
            // The last strobe cycle is the one where the counter reads 1;
            // read data is valid at that edge.
            if (r_count == CNT_W'(1)) begin
               w_stateNext  = DONE;
               w_countNext  = '0;
               w_ramRenNext = 1'b0;
               w_ramWenNext = 1'b0;
               if (r_state == INSTR) begin
                  w_iReadyNext    = 1'b1;
                  w_imemRdataNext = ram_rdata;
`ifdef MEM_REQUEST_IBUF_EN
                  w_ibufAddrNext  = r_ramAddr;
                  w_ibufDataNext  = ram_rdata;
                  w_ibufValidNext = 1'b1;
`endif
               end else begin
                  w_dReadyNext = 1'b1;
                  if (r_ramRen) begin
                     w_dmemRdataNext = ram_rdata;
                  end
               end
            end else begin
               w_countNext = r_count - CNT_W'(1);
            end
         end
         DONE: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   assign imem_rdata = r_imemRdata;
   assign i_ready    = r_iReady;
   assign dmem_rdata = r_dmemRdata;
   assign d_ready    = r_dReady;
   assign ram_addr   = r_ramAddr;
   assign ram_wdata  = r_ramWdata;
   assign ram_ren    = r_ramRen;
   assign ram_wen    = r_ramWen;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit
// -------------------
// Drives the request unit with directed scenarios followed by a randomized
// phase. Expected behaviour comes from a transaction-level model: each granted
// access is recorded with its start cycle, and strobe windows, ready pulses
// and returned data are derived from that start cycle with plain arithmetic.
// Two extra instances with latencies 1 and 5 share the inputs and are checked
// during a single-fetch latency sweep.
module tb_mem_request_unit;

   localparam int LAT = 2;

   logic        clk;
   logic        nrst;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        dmemRead;
   logic        dmemWrite;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;

   logic [31:0] imemRdata, dmemRdata, ramAddr, ramWdata, ramRdata;
   logic        iReady, dReady, ramRen, ramWen;
   logic [31:0] x1ImemRdata, x1DmemRdata, x1RamAddr, x1RamWdata, x1RamRdata;
   logic        x1IReady, x1DReady, x1RamRen, x1RamWen;
   logic [31:0] x5ImemRdata, x5DmemRdata, x5RamAddr, x5RamWdata, x5RamRdata;
   logic        x5IReady, x5DReady, x5RamRen, x5RamWen;

   mem_request_unit #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(LAT)) dut (
      .clk(clk), .nrst(nrst),
      .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(imemRdata), .i_ready(iReady),
      .dmem_read(dmemRead), .dmem_write(dmemWrite), .dmem_addr(dmemAddr),
      .dmem_wdata(dmemWdata), .dmem_rdata(dmemRdata), .d_ready(dReady),
      .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_ren(ramRen), .ram_wen(ramWen),
      .ram_rdata(ramRdata));

   mem_request_unit #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(1)) dutL1 (
      .clk(clk), .nrst(nrst),
      .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(x1ImemRdata), .i_ready(x1IReady),
      .dmem_read(dmemRead), .dmem_write(dmemWrite), .dmem_addr(dmemAddr),
      .dmem_wdata(dmemWdata), .dmem_rdata(x1DmemRdata), .d_ready(x1DReady),
      .ram_addr(x1RamAddr), .ram_wdata(x1RamWdata), .ram_ren(x1RamRen), .ram_wen(x1RamWen),
      .ram_rdata(x1RamRdata));

   mem_request_unit #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(5)) dutL5 (
      .clk(clk), .nrst(nrst),
      .imem_req(imemReq), .imem_addr(imemAddr), .imem_rdata(x5ImemRdata), .i_ready(x5IReady),
      .dmem_read(dmemRead), .dmem_write(dmemWrite), .dmem_addr(dmemAddr),
      .dmem_wdata(dmemWdata), .dmem_rdata(x5DmemRdata), .d_ready(x5DReady),
      .ram_addr(x5RamAddr), .ram_wdata(x5RamWdata), .ram_ren(x5RamRen), .ram_wen(x5RamWen),
      .ram_rdata(x5RamRdata));

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM behaviour: 64 words addressed by addr[7:2]; read data is presented
   // mid-cycle for whatever address each instance is driving.
   logic [31:0] ramMem [0:63];
   logic [31:0] modelMem [0:63];

   function automatic logic [31:0] defaultWord(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      return modelMem[a[7:2]];
   endfunction

   always @(negedge clk) begin
      ramRdata   <= ramMem[ramAddr[7:2]];
      x1RamRdata <= ramMem[x1RamAddr[7:2]];
      x5RamRdata <= ramMem[x5RamAddr[7:2]];
   end

   always @(posedge clk) begin
      if (ramWen) ramMem[ramAddr[7:2]] <= ramWdata;
   end

   // Transaction model state
   int          cyc;
   bit          act;
   int          aStart;
   bit          aData, aRead, aWrite;
   logic [31:0] aAddr, aWdata;
   bit          lastData;
   int          freeAt;
   logic [31:0] expImem, expDmem;
   bit          inAcc, expRen, expWen, expIReady, expDReady, resetEdge;
   bit          randomMode, autoDrop, sweepArm, sweepOn;
   int          sweepStart;
   int          checks, errors;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic checkOutput();
      checkVal("ram_ren", 32'(ramRen), 32'(expRen));
      checkVal("ram_wen", 32'(ramWen), 32'(expWen));
      checkVal("i_ready", 32'(iReady), 32'(expIReady));
      checkVal("d_ready", 32'(dReady), 32'(expDReady));
      checkVal("imem_rdata", imemRdata, expImem);
      checkVal("dmem_rdata", dmemRdata, expDmem);
      if (inAcc) checkVal("ram_addr", ramAddr, aAddr);
      if (expWen) checkVal("ram_wdata", ramWdata, aWdata);
      if (resetEdge) begin
         checkVal("reset_ram_addr", ramAddr, 32'h0);
         checkVal("reset_ram_wdata", ramWdata, 32'h0);
      end
      if (sweepOn) begin
         checkVal("L1_ren", 32'(x1RamRen), 32'(cyc > sweepStart && cyc <= sweepStart + 1));
         checkVal("L1_i_ready", 32'(x1IReady), 32'(cyc == sweepStart + 2));
         checkVal("L5_ren", 32'(x5RamRen), 32'(cyc > sweepStart && cyc <= sweepStart + 5));
         checkVal("L5_i_ready", 32'(x5IReady), 32'(cyc == sweepStart + 6));
         checkVal("L1_wen", 32'(x1RamWen), 32'h0);
         checkVal("L5_wen", 32'(x5RamWen), 32'h0);
         checkVal("L1_d_ready", 32'(x1DReady), 32'h0);
         checkVal("L5_d_ready", 32'(x5DReady), 32'h0);
         checkVal("L1_dmem_rdata", x1DmemRdata, 32'h0);
         checkVal("L5_dmem_rdata", x5DmemRdata, 32'h0);
         checkVal("L1_ram_wdata", x1RamWdata, 32'h0);
         checkVal("L5_ram_wdata", x5RamWdata, 32'h0);
         if (x1RamRen) checkVal("L1_ram_addr", x1RamAddr, 32'h80);
         if (x5RamRen) checkVal("L5_ram_addr", x5RamAddr, 32'h80);
      end
   endtask

   // Model update for the edge that ends the current cycle, then the edge
   // itself, then expectations for the new cycle and the comparison.
   task automatic tick();
      resetEdge = 1'b0;
      if (!nrst) begin
         act       = 1'b0;
         lastData  = 1'b0;
         freeAt    = cyc + 1;
         expImem   = '0;
         expDmem   = '0;
         resetEdge = 1'b1;
      end else begin
         if (act && cyc == aStart + LAT) begin
            if (!aData) expImem = modelRead(aAddr);
            else if (aWrite) modelMem[aAddr[7:2]] = aWdata;
            else expDmem = modelRead(aAddr);
         end
         if (cyc >= freeAt && (imemReq || dmemRead || dmemWrite)) begin
            aData    = (dmemRead || dmemWrite) && !(imemReq && lastData);
            act      = 1'b1;
            aStart   = cyc;
            lastData = aData;
            freeAt   = cyc + LAT + 2;
            aRead    = dmemRead;
            aWrite   = dmemWrite;
            aAddr    = aData ? dmemAddr : imemAddr;
            aWdata   = dmemWdata;
         end
         if (sweepArm) begin
            sweepArm   = 1'b0;
            sweepOn    = 1'b1;
            sweepStart = cyc;
         end
      end
      @(posedge clk);
      cyc++;
      inAcc     = act && cyc > aStart && cyc <= aStart + LAT;
      expRen    = inAcc && (!aData || (aRead && !aWrite));
      expWen    = inAcc && aData && aWrite;
      expIReady = act && !aData && cyc == aStart + LAT + 1;
      expDReady = act && aData && cyc == aStart + LAT + 1;
      #1 checkOutput();
   endtask

   function automatic logic [31:0] randAddr();
      return {26'b0, 4'($urandom_range(15)), 2'b00};
   endfunction

   // Requestors hold their level until their ready pulse; in random mode new
   // requests appear at random and a data request is occasionally dropped
   // mid-access, which must not abort it.
   task automatic applyStimulus();
      @(negedge clk);
      if (autoDrop) begin
         if (expIReady) imemReq = 1'b0;
         if (expDReady) begin
            dmemRead  = 1'b0;
            dmemWrite = 1'b0;
         end
      end
      if (randomMode) begin
         if (act && aData && cyc > aStart && cyc <= aStart + LAT && $urandom_range(7) == 0) begin
            dmemRead  = 1'b0;
            dmemWrite = 1'b0;
         end
         if (!imemReq) begin
            imemAddr = randAddr();
            if ($urandom_range(2) == 0) imemReq = 1'b1;
         end
         if (!(dmemRead || dmemWrite)) begin
            dmemAddr  = randAddr();
            dmemWdata = $urandom();
            if ($urandom_range(2) == 0) begin
               int r;
               r = $urandom_range(3);
               dmemRead  = (r != 1);
               dmemWrite = (r == 1 || r == 2);
            end
         end
      end
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus();
         tick();
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      act = 1'b0; lastData = 1'b0; freeAt = 0; aStart = 0;
      aData = 1'b0; aRead = 1'b0; aWrite = 1'b0; aAddr = '0; aWdata = '0;
      expImem = '0; expDmem = '0;
      inAcc = 1'b0; expRen = 1'b0; expWen = 1'b0; expIReady = 1'b0; expDReady = 1'b0;
      randomMode = 1'b0; autoDrop = 1'b1; sweepArm = 1'b0; sweepOn = 1'b0; sweepStart = 0;
      for (int i = 0; i < 64; i++) begin
         ramMem[i]   <= defaultWord(32'(i * 4));
         modelMem[i]  = defaultWord(32'(i * 4));
      end
      ramMem[4]   <= 32'h00A00093;
      modelMem[4]  = 32'h00A00093;
      nrst = 1'b0; imemReq = 1'b0; imemAddr = '0;
      dmemRead = 1'b0; dmemWrite = 1'b0; dmemAddr = '0; dmemWdata = '0;

      // reset state
      runCycles(3);
      nrst = 1'b1;

      // single fetch of 0x10
      imemReq = 1'b1; imemAddr = 32'h10;
      runCycles(5);
      checkVal("fetch_word", imemRdata, 32'h00A00093);

      // store 0xDEADBEEF to 0x40; load data must stay unchanged
      dmemWrite = 1'b1; dmemAddr = 32'h40; dmemWdata = 32'hDEADBEEF;
      runCycles(5);
      checkVal("store_ram_word", ramMem[16], 32'hDEADBEEF);
      checkVal("store_keeps_dmem_rdata", dmemRdata, 32'h0);

      // both requestors held across reset exit: D, I, D, I alternation
      nrst = 1'b0; autoDrop = 1'b0;
      imemReq = 1'b1; imemAddr = 32'h20; dmemRead = 1'b1; dmemAddr = 32'h30;
      runCycles(2);
      nrst = 1'b1;
      runCycles(13);
      imemReq = 1'b0; dmemRead = 1'b0; autoDrop = 1'b1;
      while (cyc < freeAt) runCycles(1);

      // reset during the second strobe cycle of a load, then retry
      dmemRead = 1'b1; dmemAddr = 32'h24;
      runCycles(2);
      nrst = 1'b0;
      runCycles(1);
      nrst = 1'b1;
      runCycles(6);

      // latency sweep with single-cycle fetch request (drop must not abort)
      dmemRead = 1'b0; imemReq = 1'b0;
      nrst = 1'b0;
      runCycles(2);
      nrst = 1'b1;
      runCycles(1);
      imemReq = 1'b1; imemAddr = 32'h80; sweepArm = 1'b1;
      runCycles(1);
      imemReq = 1'b0;
      runCycles(8);
      sweepOn = 1'b0;
      checkVal("L1_imem_rdata", x1ImemRdata, defaultWord(32'h80));
      checkVal("L5_imem_rdata", x5ImemRdata, defaultWord(32'h80));

      // randomized traffic
      randomMode = 1'b1;
      runCycles(600);
      randomMode = 1'b0;
      imemReq = 1'b0; dmemRead = 1'b0; dmemWrite = 1'b0;
      runCycles(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Parametrised request unit that shares one single-port, fixed-latency RAM between instruction fetch and data load/store.
- Replaces the fixed-latency, instruction-only handshake of the current ram wrapper.
- Arbitrates between the two requestors with data priority and anti-starvation alternation.
- Generates the i_ready / d_ready stall handshakes consumed by the PC and the register writeback path.

Parameters:
- ADDR_W, 32, address width, shared by both requestors and the RAM.
- DATA_W, 32, data width.
- RAM_LATENCY, 2, cycles the RAM strobe is held before read data is valid; legal range 1..15.

Ports:
- clk  input  1  system clock
- nrst  input  1  synchronous active-low reset
- imem_req  input  1  instruction fetch request; level, held until i_ready
- imem_addr  input  ADDR_W  fetch address (PC)
- imem_rdata  output  DATA_W  fetched instruction
- i_ready  output  1  one-cycle fetch-complete pulse
- dmem_read  input  1  data load request; level
- dmem_write  input  1  data store request; level
- dmem_addr  input  ADDR_W  data address (ALU result)
- dmem_wdata  input  DATA_W  store data
- dmem_rdata  output  DATA_W  load data
- d_ready  output  1  one-cycle data-complete pulse
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  DATA_W  RAM write data
- ram_ren  output  1  RAM read strobe
- ram_wen  output  1  RAM write strobe
- ram_rdata  input  DATA_W  RAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is synchronous and active-low.
- Reset values: all outputs 0, state IDLE, counter 0, last_grant = INSTR.
- States: IDLE, DATA, INSTR, DONE. All outputs are registered.
- IDLE, grant rules (sampled at the edge):
  - No request pending: stay in IDLE.
  - Only one requestor pending: grant it.
  - Both pending: grant DATA, unless last_grant == DATA, in which case grant INSTR (alternation).
- IDLE on grant: latch the address (and store data); load counter = RAM_LATENCY; update last_grant.
- DATA / INSTR:
  - ram_addr holds the latched address.
  - DATA: ram_ren = dmem_read & ~dmem_write; ram_wen = dmem_write (write wins if both are asserted).
  - INSTR: ram_ren = 1.
  - Counter decrements every cycle. When it reaches 1, capture ram_rdata at that edge into imem_rdata or dmem_rdata (reads only; stores leave dmem_rdata unchanged) and go to DONE.
- DONE:
  - Strobes are 0. Exactly one of i_ready / d_ready is 1 for this cycle.
  - Requests are ignored. Next state is IDLE.
- Latency: request sampled in IDLE at cycle N → strobes asserted in cycles N+1..N+RAM_LATENCY → ready pulse in cycle N+RAM_LATENCY+1. Back-to-back accesses have a minimum spacing of RAM_LATENCY+2 cycles.
- imem_rdata / dmem_rdata hold their last captured value until the next completion of the same type.
- Request inputs are not re-sampled mid-access. A requestor dropping its request mid-access does not abort; the access completes and still pulses ready.
- Reset mid-access: strobes drop at the reset edge, no ready pulse is produced, the next access starts from IDLE.
- Counter width is $clog2(RAM_LATENCY+1).

Optional Feature:
- Macro: MEM_REQUEST_IBUF_EN.
- Defined: adds a one-entry fetch buffer (ibuf_addr, ibuf_data, ibuf_valid).
  - Hit: in IDLE, with imem_req set, no DATA grant, and imem_addr == ibuf_addr with ibuf_valid set, go directly to DONE with i_ready and imem_rdata = ibuf_data. The RAM is not accessed; latency is 1 cycle.
  - Fill: every INSTR completion updates the buffer and sets ibuf_valid.
  - Invalidate: a DATA store to ibuf_addr clears ibuf_valid.
  - Reset clears ibuf_valid.
- Undefined: no buffer; every fetch goes to the RAM.

Test Plan:
- Fetch, RAM_LATENCY=2, imem_addr=0x10, RAM returns 0x00A00093 → ram_ren high in cycles 1-2, i_ready pulse in cycle 3, imem_rdata=0x00A00093.
- Store dmem_addr=0x40, wdata=0xDEADBEEF → ram_wen high for 2 cycles, ram_wdata=0xDEADBEEF, d_ready pulse in cycle 3, dmem_rdata unchanged.
- imem_req and dmem_read asserted together at reset exit → DATA served first; then, with both still held, INSTR (alternation); then DATA again.
- nrst low at the second strobe cycle of a load → strobes 0 on the next cycle, no d_ready, all outputs 0, next request served normally.
- RAM_LATENCY=1 and RAM_LATENCY=5 sweep → ready pulse at exactly N+L+1.
- With MEM_REQUEST_IBUF_EN: fetch 0x10 twice → second fetch gives i_ready the cycle after the request with no ram_ren. Then store to 0x10 and fetch 0x10 → full RAM latency.
